// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even and valid/ready flow control.
// Define FP_ADD_FLAGS_EN to add the o_flags = {invalid, overflow, inexact} output.
module fp_add_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [EXP_W+MAN_W:0]     i_a,
   input  logic [EXP_W+MAN_W:0]     i_b,
   input  logic                     i_sub,
   output logic                     o_valid,
   input  logic                     i_ready,
`ifdef FP_ADD_FLAGS_EN
   output logic [2:0]               o_flags,
`endif
   output logic [EXP_W+MAN_W:0]     o_res
);

   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int SW  = MAN_W + 4;
   localparam int AW  = MAN_W + 5;
   localparam int RW  = MAN_W + 2;
   localparam int EW  = EXP_W + 2;
   localparam int LZW = $clog2(AW) + 1;
   localparam logic signed [EW-1:0] EMAX = EW'((2 ** EXP_W) - 1);

   logic adv;
   logic v1, v2, v3;

   logic               a_sign, b_sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic [EXP_W-1:0]   a_exp, b_exp, big_exp, sml_exp, diff;
   logic [MAN_W-1:0]   a_man, b_man, big_man, sml_man;
   logic               a_big, big_sign, sml_sign;
   logic [MAN_W:0]     sml_sig;
   logic [SW-1:0]      aligned;
   logic [2*SW-1:0]    wide;
   logic               spec_nan, spec_inf, both_zero;
   logic [W-1:0]       spec_res;

   logic               s1_sign, s1_sub, s1_special, s1_invalid;
   logic [EXP_W-1:0]   s1_exp;
   logic [SW-1:0]      s1_big, s1_sml;
   logic [W-1:0]       s1_spec_res;

   logic               s2_sign, s2_special, s2_invalid;
   logic [EXP_W-1:0]   s2_exp;
   logic [AW-1:0]      s2_sum;
   logic [W-1:0]       s2_spec_res;

   logic [LZW-1:0]     lz;
   logic               found;
   logic [SW-1:0]      norm;
   logic signed [EW-1:0] exp_n, exp_r;
   logic [RW-1:0]      rnd;
   logic [MAN_W-1:0]   man_r;
   logic               inc, ovf, ftz, is_normal;
   logic [W-1:0]       res_next;

   assign adv     = !v3 || i_ready;
   assign o_ready = adv;
   assign o_valid = v3;

   assign a_sign = i_a[W-1];
   assign a_exp  = i_a[W-2:MAN_W];
   assign a_man  = i_a[MAN_W-1:0];
   assign b_sign = i_b[W-1] ^ i_sub;
   assign b_exp  = i_b[W-2:MAN_W];
   assign b_man  = i_b[MAN_W-1:0];

   // Exponent zero means zero here: subnormals are treated as signed zero on the way in.
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == '1) && (a_man == '0);
   assign b_inf  = (b_exp == '1) && (b_man == '0);
   assign a_nan  = (a_exp == '1) && (a_man != '0);
   assign b_nan  = (b_exp == '1) && (b_man != '0);

   assign a_big    = (a_zero ? '0 : {a_exp, a_man}) >= (b_zero ? '0 : {b_exp, b_man});
   assign big_sign = a_big ? a_sign : b_sign;
   assign big_exp  = a_big ? a_exp  : b_exp;
   assign big_man  = a_big ? a_man  : b_man;
   assign sml_sign = a_big ? b_sign : a_sign;
   assign sml_exp  = a_big ? b_exp  : a_exp;
   assign sml_man  = a_big ? b_man  : a_man;
   assign sml_sig  = (sml_exp == '0) ? '0 : {1'b1, sml_man};
   assign diff     = big_exp - sml_exp;

   assign spec_nan  = a_nan || b_nan || (a_inf && b_inf && (a_sign != b_sign));
   assign spec_inf  = a_inf || b_inf;
   assign both_zero = a_zero && b_zero;

   // Align the smaller significand; everything shifted past R is ORed into the sticky bit.
   always_comb begin
      wide    = '0;
      aligned = '0;
      if (32'(diff) >= MAN_W + 3) begin
         aligned = {{(SW-1){1'b0}}, |sml_sig};
      end else begin
         wide    = {sml_sig, 3'b000, {SW{1'b0}}} >> diff;
         aligned = wide[2*SW-1:SW];
         aligned[0] = wide[SW] | (|wide[SW-1:0]);
      end
   end

   always_comb begin
      if (spec_nan)
         spec_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      else if (spec_inf)
         spec_res = {(a_inf ? a_sign : b_sign), {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         spec_res = {a_sign & b_sign, {(W-1){1'b0}}};
   end

   always_comb begin
      lz    = '0;
      found = 1'b0;
      for (int i = AW - 2; i >= 0; i--) begin
         if (!found && s2_sum[i]) begin
            lz    = LZW'(AW - 2 - i);
            found = 1'b1;
         end
      end
   end

   // Normalise to a leading one at the top of norm, then round to nearest even.
   always_comb begin
      if (s2_sum[AW-1]) begin
         norm  = {s2_sum[AW-1:2], s2_sum[1] | s2_sum[0]};
         exp_n = EW'(s2_exp) + EW'(1);
      end else begin
         norm  = s2_sum[SW-1:0] << lz;
         exp_n = EW'(s2_exp) - EW'(lz);
      end
      inc = norm[2] && (norm[1] || norm[0] || norm[3]);
      rnd = {1'b0, norm[SW-1:3]} + RW'(inc);
      if (rnd[RW-1]) begin
         exp_r = exp_n + EW'(1);
         man_r = rnd[MAN_W:1];
      end else begin
         exp_r = exp_n;
         man_r = rnd[MAN_W-1:0];
      end
      ovf       = (exp_r >= EMAX);
      ftz       = exp_r[EW-1] || (exp_r == '0);
      is_normal = !s2_special && (s2_sum != '0);
      if (s2_special)
         res_next = s2_spec_res;
      else if (s2_sum == '0)
         res_next = '0;
      else if (ovf)
         res_next = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (ftz)
         res_next = {s2_sign, {(W-1){1'b0}}};
      else
         res_next = {s2_sign, exp_r[EXP_W-1:0], man_r};
   end

   // All stages move together whenever the output register is free or being drained.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         v3    <= 1'b0;
         o_res <= '0;
`ifdef FP_ADD_FLAGS_EN
         o_flags <= '0;
`endif
      end else if (adv) begin
         v1          <= i_valid;
         s1_sign     <= big_sign;
         s1_sub      <= big_sign != sml_sign;
         s1_exp      <= big_exp;
         s1_big      <= {1'b1, big_man, 3'b000};
         s1_sml      <= aligned;
         s1_special  <= spec_nan || spec_inf || both_zero;
         s1_invalid  <= spec_nan;
         s1_spec_res <= spec_res;

         v2          <= v1;
         s2_sign     <= s1_sign;
         s2_exp      <= s1_exp;
         s2_sum      <= s1_sub ? ({1'b0, s1_big} - {1'b0, s1_sml})
                               : ({1'b0, s1_big} + {1'b0, s1_sml});
         s2_special  <= s1_special;
         s2_invalid  <= s1_invalid;
         s2_spec_res <= s1_spec_res;

         v3          <= v2;
         o_res       <= res_next;
`ifdef FP_ADD_FLAGS_EN
         o_flags     <= {s2_special && s2_invalid,
                         is_normal && ovf,
                         is_normal && (norm[2] || norm[1] || norm[0] || ovf || ftz)};
`endif
      end
   end

endmodule
